// File: rtl/layer_serializer.sv
// layer_serializer
//   Captures a full vector of NN neuron outputs when every per-neuron valid
//   strobe is high in the same cycle, then streams the elements one per
//   cycle in ascending index order toward the next layer.
//
// Parameters
//   NN        : number of neuron outputs per vector
//   dataWidth : width of each neuron output
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high
//   i_valid   : per-neuron valid strobes (capture only when all are 1)
//   i_data    : packed neuron outputs, neuron k at [k*dataWidth +: dataWidth]
//   o_valid   : o_data carries an element
//   o_data    : serialized element
//   o_index   : neuron index of o_data
//   o_last    : marks the element with index NN-1
//   busy      : high while serializing
//   o_overrun : sticky, set when a captured vector had to be dropped
module layer_serializer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16,
    localparam int IDXW     = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic [IDXW-1:0]         o_index,
    output logic                    o_last,
    output logic                    busy,
    output logic                    o_overrun
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    logic [IDXW-1:0]      counter;   // index of the element currently on o_data
    logic [dataWidth-1:0] buffer [NN];

    logic            capture;
    logic            at_last;
    logic            load;
    logic [IDXW-1:0] nxt_idx;

    assign capture = &i_valid;
    assign at_last = (counter == LAST_IDX);
    assign nxt_idx = counter + 1'b1;
    // A new vector is accepted when nothing is pending: either idle, or the
    // final element of the current vector is on the output this cycle.
    assign load    = capture && ((state == IDLE) || at_last);

    // Outputs are registered one step ahead of the counter: on the load edge
    // element 0 is taken straight from i_data so it appears the very next
    // cycle, and each later edge presents buffer[counter+1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            for (int unsigned k = 0; k < NN; k++) begin
                buffer[k] <= '0;
            end
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_index   <= '0;
            o_last    <= 1'b0;
            busy      <= 1'b0;
            o_overrun <= 1'b0;
        end else if (load) begin
            for (int unsigned k = 0; k < NN; k++) begin
                buffer[k] <= i_data[k*dataWidth +: dataWidth];
            end
            state   <= SHIFT;
            counter <= '0;
            o_valid <= 1'b1;
            o_data  <= i_data[dataWidth-1:0];
            o_index <= '0;
            o_last  <= (LAST_IDX == '0);
            busy    <= 1'b1;
        end else if ((state == SHIFT) && !at_last) begin
            counter <= nxt_idx;
            o_valid <= 1'b1;
            o_data  <= buffer[nxt_idx];
            o_index <= nxt_idx;
            o_last  <= (nxt_idx == LAST_IDX);
            busy    <= 1'b1;
            if (capture) begin
                o_overrun <= 1'b1;
            end
        end else begin
            state   <= IDLE;
            counter <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_index <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer
//   Drives layer_serializer (NN=10, dataWidth=16) with directed vectors and
//   randomized traffic and compares every output against a queue-based model:
//   an accepted vector appends NN elements to a pending queue, one element is
//   shown per cycle, and a capture while elements are still pending is dropped
//   and flags overrun.
module tb_layer_serializer;

    localparam int NN   = 10;
    localparam int DW   = 16;
    localparam int IDXW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NN-1:0]        i_valid;
    logic [NN*DW-1:0]     i_data;
    logic                 o_valid;
    logic [DW-1:0]        o_data;
    logic [IDXW-1:0]      o_index;
    logic                 o_last;
    logic                 busy;
    logic                 o_overrun;

    int n_checks = 0;
    int n_errors = 0;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_index   (o_index),
        .o_last    (o_last),
        .busy      (busy),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        int unsigned   idx;
        bit            last;
    } elem_t;

    elem_t pend[$];
    elem_t cur;
    bit    cur_v;
    bit    m_ovr;

    task automatic model_clear();
        pend.delete();
        cur_v = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_edge();
        elem_t e;
        if (&i_valid) begin
            if (pend.size() == 0) begin
                for (int k = 0; k < NN; k++) begin
                    e.d    = i_data[k*DW +: DW];
                    e.idx  = k;
                    e.last = (k == NN - 1);
                    pend.push_back(e);
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (pend.size() > 0) begin
            cur   = pend.pop_front();
            cur_v = 1'b1;
        end else begin
            cur_v = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("o_valid",   32'(o_valid),   32'(cur_v));
        check("o_data",    32'(o_data),    cur_v ? 32'(cur.d) : 32'd0);
        check("o_index",   32'(o_index),   cur_v ? cur.idx : 32'd0);
        check("o_last",    32'(o_last),    cur_v ? 32'(cur.last) : 32'd0);
        check("busy",      32'(busy),      32'(cur_v));
        check("o_overrun", 32'(o_overrun), 32'(m_ovr));
    endtask

    // One clock: model follows the edge, outputs compared 1ns later.
    task automatic step();
        @(posedge clk);
        if (rst) model_clear();
        else     model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive_vec(input logic [DW-1:0] base);
        for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = base + DW'(k);
        i_valid = '1;
    endtask

    task automatic drive_idle();
        i_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        compare_all();
        step();
        #3 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        i_valid = '0;
        i_data  = '0;
        model_clear();
        #2;
        compare_all();
        steps(2);
        #3 rst = 1'b0;

        // single vector, accepted on the first edge after reset release
        drive_vec(16'h0100);
        step();
        check("first_elem", 32'(o_data), 32'h0100);
        drive_idle();
        steps(12);

        // partial valid is ignored
        drive_vec(16'h0300);
        i_valid = 10'h1FF;
        step();
        drive_idle();
        steps(3);

        // back-to-back: second vector captured while index 9 is shown
        drive_vec(16'h0100);
        step();
        drive_idle();
        steps(9);
        check("idx9_before_b2b", 32'(o_index), 32'd9);
        drive_vec(16'h0200);
        step();
        check("b2b_handoff", 32'(o_data), 32'h0200);
        drive_idle();
        steps(12);

        // overrun: capture while index 4 is shown
        drive_vec(16'h0100);
        step();
        drive_idle();
        steps(4);
        drive_vec(16'h0200);
        step();
        drive_idle();
        steps(15);
        check("overrun_sticky", 32'(o_overrun), 32'd1);

        // asynchronous reset while index 5 is shown
        do_reset();
        drive_vec(16'h0100);
        step();
        drive_idle();
        steps(5);
        rst = 1'b1;
        model_clear();
        #1;
        compare_all();
        step();
        #3 rst = 1'b0;
        drive_vec(16'h0100);
        step();
        drive_idle();
        steps(11);

        // data hold: inputs go to all-ones right after capture
        drive_vec(16'h0100);
        step();
        i_data = '1;
        steps(11);

        // NN-element vector right after idle with random data, then random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = DW'($urandom);
            if (r < 4)      i_valid = '1;
            else if (r < 7) i_valid = NN'($urandom) & 10'h3FE;
            else            i_valid = '0;
            if (r == 19 && $urandom_range(0, 7) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        drive_idle();
        steps(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
